cgra_config_emitter: RTL
========================

Name: cgra_config_emitter

Overview:
Downstream stage of the CGRA edge router. Once routing finishes, it scans the 16-entry routing table, one 6-bit entry per PE, and serializes it into a stream of per-PE configuration words with a valid/ready handshake. The consumer is the bitstream packer / configuration loader. The stream ends with a trailer word, and an optional checksum word can precede the trailer.

Parameters:
NUM_PE, 16, number of PEs / routing-table entries (4x4 grid)
ADDR_W, 4, PE index width; NUM_PE <= 2**ADDR_W
ENTRY_W, 6, table entry width: [5:4] bypass count; [3:0] direction flags, bit3 right, bit2 left, bit1 top, bit0 bot
MAX_BYPASS, 2, legal maximum of the bypass field
SKIP_EMPTY, 1, 1 = do not emit PEs whose entry is all zero

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a scan when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the trailer handshake
rd_en  out  1  table read strobe
rd_addr  out  ADDR_W  table read address
rd_data  in  ENTRY_W  table entry, valid the cycle after rd_en
cfg_valid  out  1  output word valid
cfg_ready  in  1  consumer ready
cfg_data  out  ADDR_W+ENTRY_W  {pe_idx, entry}, or a trailer/checksum payload
cfg_last  out  1  marks the trailer word
err_bypass  out  1  sticky: some entry had bypass > MAX_BYPASS

Behaviour:
- Reset is clk, with reset synchronous and active-high. It forces IDLE and clears all outputs to 0: busy, done, rd_en, rd_addr, cfg_valid, cfg_data, cfg_last, err_bypass, plus the index, count and checksum registers. Reset wins over every other event, including mid-scan and mid-handshake.
- States: IDLE, READ, CAPTURE, EMIT, CSUM, TRAIL, DONE.
- IDLE:
  - start=1 sets busy=1, clears index/count/checksum/err_bypass, and moves to READ.
  - start is ignored in every state other than IDLE.
- READ: rd_en=1 and rd_addr=index for this one cycle; go to CAPTURE.
- CAPTURE:
  - Latch word = {index, rd_data}.
  - If rd_data[5:4] > MAX_BYPASS, set err_bypass. The entry is still emitted.
  - If SKIP_EMPTY=1 and rd_data==0: no emit. Go to READ with index+1, or to CSUM/TRAIL when index==NUM_PE-1.
  - Otherwise go to EMIT.
- EMIT:
  - cfg_valid=1, cfg_last=0, and cfg_data is held stable until cfg_ready=1.
  - On handshake: count+1, checksum ^= word, cfg_valid drops next cycle.
  - If index==NUM_PE-1, go to CSUM (macro on) or TRAIL; else go to READ with index+1.
  - The minimum cost is 3 cycles per emitted entry with no backpressure.
- TRAIL:
  - cfg_valid=1, cfg_last=1, cfg_data = count zero-extended. count ranges 0..NUM_PE.
  - On handshake go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- cfg_valid never depends combinationally on cfg_ready. Once asserted, cfg_valid stays high until its handshake completes.
- Index arithmetic is unsigned, width ADDR_W+1, so no wrap is possible at NUM_PE=16.

Optional Feature:
CFG_CHECKSUM_EN
- Defined: state CSUM is present. It emits one word with cfg_data = XOR of all emitted PE words and cfg_last=0, holds it until handshake, then goes to TRAIL. The checksum word is not included in count.
- Undefined: CSUM does not exist, and EMIT or CAPTURE at the last index goes directly to TRAIL.

Test Plan:
1. All-zero table, SKIP_EMPTY=1, cfg_ready=1, start pulse -> single word 0x000 with cfg_last=1; done pulses 1 cycle later; err_bypass=0.
2. PE0=0x08, PE5=0x11, others 0, cfg_ready=1 -> words 0x008, 0x151, then trailer 0x002 with cfg_last=1. With CFG_CHECKSUM_EN, word 0x159 appears before the trailer.
3. Same table, cfg_ready held low 5 cycles while 0x151 is valid -> cfg_data and cfg_valid are stable for all 5 cycles; the word transfers exactly once when cfg_ready rises.
4. PE7=0x31 (bypass 3) -> err_bypass rises after the CAPTURE of PE7 and stays high until the next accepted start; word 0x1F1 is still emitted.
5. start pulsed again mid-scan -> ignored, sequence unchanged. Then reset asserted during EMIT -> next cycle cfg_valid=0, busy=0, state IDLE, and a fresh start rescans from PE0.
6. SKIP_EMPTY=0, all-zero table -> 16 words 0x000..0x3C0, pe_idx incrementing, then trailer 0x010.

Source files
------------

// File: rtl/cgra_config_emitter.sv
// cgra_config_emitter: walks the CGRA routing table after routing completes
// and streams one {pe_idx, entry} configuration word per PE over a
// valid/ready handshake, finishing with a trailer word that carries the
// number of PE words emitted.
// Optional build macro CFG_CHECKSUM_EN adds a checksum word (XOR of all
// emitted PE words) just before the trailer.
module cgra_config_emitter #(
  parameter int NUM_PE     = 16,
  parameter int ADDR_W     = 4,
  parameter int ENTRY_W    = 6,
  parameter int MAX_BYPASS = 2,
  parameter int SKIP_EMPTY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [ENTRY_W-1:0]        rd_data,
  output logic                      cfg_valid,
  input  logic                      cfg_ready,
  output logic [ADDR_W+ENTRY_W-1:0] cfg_data,
  output logic                      cfg_last,
  output logic                      err_bypass
);

  localparam int WORD_W = ADDR_W + ENTRY_W;
  localparam int CNT_W  = $clog2(NUM_PE + 1);
  // Index carries one extra bit so stepping past the last PE cannot wrap.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_PE - 1);
  localparam logic [1:0]      MAX_BP   = 2'(MAX_BYPASS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    TRAIL   = 3'd4,
`ifdef CFG_CHECKSUM_EN
    CSUM    = 3'd6,
`endif
    DONE    = 3'd5
  } state_t;

  // Where the scan goes once the last table entry has been handled.
`ifdef CFG_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = TRAIL;
`endif

  state_t state, state_next;

  logic [ADDR_W:0]   index;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] word;
`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
`endif

  logic is_last;
  logic skip_entry;

  function automatic logic bypass_illegal(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1 -: 2] > MAX_BP;
  endfunction

  function automatic logic entry_skipped(input logic [ENTRY_W-1:0] entry);
    return (SKIP_EMPTY != 0) && (entry == '0);
  endfunction

  assign is_last    = (index == LAST_IDX);
  assign skip_entry = entry_skipped(rd_data);

  // State register; reset overrides everything, including a pending handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. cfg_ready only matters in states that present a word.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = CAPTURE;
      CAPTURE: begin
        if (skip_entry) state_next = is_last ? TAIL : READ;
        else            state_next = EMIT;
      end
      EMIT:    if (cfg_ready) state_next = is_last ? TAIL : READ;
`ifdef CFG_CHECKSUM_EN
      CSUM:    if (cfg_ready) state_next = TRAIL;
`endif
      TRAIL:   if (cfg_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from state, so cfg_valid never looks at cfg_ready.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    unique case (state)
      IDLE:    ;
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = index[ADDR_W-1:0];
      end
      CAPTURE: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = word;
      end
`ifdef CFG_CHECKSUM_EN
      CSUM: begin
        busy      = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = checksum;
      end
`endif
      TRAIL: begin
        busy      = 1'b1;
        cfg_valid = 1'b1;
        cfg_last  = 1'b1;
        cfg_data  = {{(WORD_W - CNT_W){1'b0}}, count};
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Scan bookkeeping: index, latched word, emitted count, checksum, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      index      <= '0;
      count      <= '0;
      word       <= '0;
      err_bypass <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            index      <= '0;
            count      <= '0;
            err_bypass <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        CAPTURE: begin
          word <= {index[ADDR_W-1:0], rd_data};
          if (bypass_illegal(rd_data)) err_bypass <= 1'b1;
          if (skip_entry && !is_last) index <= index + (ADDR_W + 1)'(1);
        end
        EMIT: begin
          if (cfg_ready) begin
            count <= count + CNT_W'(1);
`ifdef CFG_CHECKSUM_EN
            checksum <= checksum ^ word;
`endif
            if (!is_last) index <= index + (ADDR_W + 1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
